// File: rtl/edge_detect_pkg.sv
// Shared types and edge-mode encodings for the multi-channel edge detector.
// Mode bit 0 selects rising edges, bit 1 selects falling edges.
package edge_detect_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t EDGE_OFF  = 2'b00;
  localparam mode_t EDGE_RISE = 2'b01;
  localparam mode_t EDGE_FALL = 2'b10;
  localparam mode_t EDGE_BOTH = 2'b11;

  // True when a transition to new_level is one the mode asks to report.
  function automatic logic edge_selected(input mode_t m, input logic new_level);
    return new_level ? m[0] : m[1];
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detect channel: synchroniser, persistence filter, edge qualification,
// registered pulse and sticky write-1-to-clear event/overrun flags.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  signal_in,
  input  mode_t mode,
  input  logic  clear,
  output logic  level_out,
  output logic  pulse_out,
  output logic  event_flag,
  output logic  overrun
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          s;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;
  logic          event_q;
  logic          overrun_q;
  logic          toggle;
  logic          pulse_nxt;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = signal_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= signal_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A new level is accepted only once it has disagreed for FILTER_CYCLES samples.
  assign toggle    = (s != level_q) && (cnt_q == CNT_LAST);
  assign pulse_nxt = toggle && edge_selected(mode, ~level_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      event_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (toggle) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      pulse_q   <= pulse_nxt;
      // A pulse coinciding with clear wins for event, so no event is ever dropped.
      event_q   <= pulse_nxt | (event_q & ~clear);
      overrun_q <= (pulse_nxt & event_q & ~clear) | (overrun_q & ~clear);
    end
  end

  assign level_out  = level_q;
  assign pulse_out  = pulse_q;
  assign event_flag = event_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/edge_detect_multi.sv
// CHANNELS independent filtered edge detectors for asynchronous pins and strobes;
// any_event summarises the sticky event flags for the register block.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   event_flag,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  any_event
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_detect_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .signal_in (signal_in[i]),
        .mode      (mode_t'(mode[2*i +: 2])),
        .clear     (clear[i]),
        .level_out (level_out[i]),
        .pulse_out (pulse_out[i]),
        .event_flag(event_flag[i]),
        .overrun   (overrun[i])
      );
    end
  endgenerate

  assign any_event = |event_flag;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi: directed stimulus pushes expected pulse
// cycles into a queue; a negedge monitor matches every pulse_out against it.
module tb_edge_detect_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] signal_in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] level_out;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] event_flag;
  logic [CH-1:0] overrun;
  logic          any_event;

  edge_detect_multi #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .signal_in (signal_in),
    .mode      (mode),
    .clear     (clear),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .event_flag(event_flag),
    .overrun   (overrun),
    .any_event (any_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int at;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int ch, input int at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  // Monitor: every pulse must match a queued expectation; stale entries are misses.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (pulse_out[c]) begin
          idx = -1;
          foreach (sb[j]) if (sb[j].ch == c && sb[j].at == cyc) idx = j;
          n_tests++;
          if (idx >= 0) begin
            sb.delete(idx);
          end else begin
            n_fail++;
            $display("FAIL unexpected_pulse ch%0d: pulse_out=1 at cycle %0d, required 0", c, cyc);
          end
        end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missed_pulse ch%0d: pulse_out=0 at cycle %0d, required 1", sb[j].ch, sb[j].at);
          sb.delete(j);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int base;
    logic [1:0]    rm [CH];
    logic [CH-1:0] lvl, ev, ov;

    reset = 1'b1; signal_in = '0; clear = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", level_out, 0);
    check("reset_pulse", pulse_out, 0);
    check("reset_event", event_flag, 0);
    check("reset_overrun", overrun, 0);
    check("reset_any", any_event, 0);
    reset = 1'b0;

    // Rise on ch0: visible exactly 5 edges after the change.
    set_mode(0, 2'b01);
    t = cyc; signal_in[0] = 1'b1; expect_pulse(0, t + 5);
    wait_until(t + 4); check("rise_level_early", level_out[0], 0);
    wait_until(t + 5);
    check("rise_level", level_out[0], 1);
    check("rise_pulse", pulse_out[0], 1);
    check("rise_event", event_flag[0], 1);
    check("rise_any", any_event, 1);
    wait_until(t + 6); check("rise_pulse_end", pulse_out[0], 0);
    wait_until(t + 8); signal_in[0] = 1'b0;   // fall not selected: no pulse
    wait_until(t + 16);

    // Glitch on ch1: 2 cycles suppressed, 3 cycles accepted both ways.
    set_mode(1, 2'b11);
    t = cyc; signal_in[1] = 1'b1;
    wait_until(t + 2); signal_in[1] = 1'b0;
    wait_until(t + 8);
    check("glitch_level", level_out[1], 0);
    check("glitch_event", event_flag[1], 0);
    t = cyc; signal_in[1] = 1'b1; expect_pulse(1, t + 5);
    wait_until(t + 3); signal_in[1] = 1'b0; expect_pulse(1, t + 8);
    wait_until(t + 9);
    check("pulse3_level", level_out[1], 0);
    check("pulse3_event", event_flag[1], 1);

    // ch2 fall-only, ch3 off then both.
    set_mode(2, 2'b10); set_mode(3, 2'b00);
    t = cyc; signal_in[3:2] = 2'b11;
    wait_until(t + 5);
    check("mode_level_hi", level_out[3:2], 2'b11);
    check("mode_no_event", event_flag[3:2], 2'b00);
    set_mode(3, 2'b11);
    wait_until(t + 8); signal_in[3:2] = 2'b00;
    expect_pulse(2, t + 13); expect_pulse(3, t + 13);
    wait_until(t + 16); signal_in[3] = 1'b1; expect_pulse(3, t + 21);
    wait_until(t + 22);
    check("mode_event", event_flag[3:2], 2'b11);
    check("mode_level_end", level_out[3:2], 2'b10);

    // Flags on ch0.
    clear[0] = 1'b1; wait_until(cyc + 1); clear[0] = 1'b0;
    check("preclear_event", event_flag[0], 0);
    t = cyc; signal_in[0] = 1'b1; expect_pulse(0, t + 5);
    wait_until(t + 8); signal_in[0] = 1'b0;
    wait_until(t + 16); signal_in[0] = 1'b1; expect_pulse(0, t + 21);
    wait_until(t + 21);
    check("ovr_set", overrun[0], 1);
    check("ovr_event", event_flag[0], 1);
    wait_until(t + 22); clear[0] = 1'b1;
    wait_until(t + 23); clear[0] = 1'b0;
    check("clr_event", event_flag[0], 0);
    check("clr_overrun", overrun[0], 0);
    set_mode(0, 2'b11);
    wait_until(t + 24); signal_in[0] = 1'b0; expect_pulse(0, t + 29);
    wait_until(t + 30);
    check("fall_event", event_flag[0], 1);
    check("fall_overrun", overrun[0], 0);
    wait_until(t + 32); signal_in[0] = 1'b1; expect_pulse(0, t + 37);
    wait_until(t + 36); clear[0] = 1'b1;
    wait_until(t + 37); clear[0] = 1'b0;
    check("coinc_event", event_flag[0], 1);
    check("coinc_overrun", overrun[0], 0);
    wait_until(t + 40); signal_in[0] = 1'b0; expect_pulse(0, t + 45);
    wait_until(t + 50);

    // Reset while ch0 filter count is 1; ch0 and ch3 inputs stay high through it.
    t = cyc; signal_in[0] = 1'b1;
    wait_until(t + 3); reset = 1'b1;
    wait_until(t + 4); reset = 1'b0;
    check("rst_level", level_out, 0);
    check("rst_pulse", pulse_out, 0);
    check("rst_event", event_flag, 0);
    check("rst_overrun", overrun, 0);
    check("rst_any", any_event, 0);
    expect_pulse(0, t + 9); expect_pulse(3, t + 9);
    wait_until(t + 8); check("rst_level_early", level_out[0], 0);
    wait_until(t + 9); check("rst_level_rise", level_out[0], 1);

    // Independence: all low, clear, then staggered toggles with random modes.
    wait_until(t + 12); t = cyc; signal_in = '0;
    expect_pulse(0, t + 5); expect_pulse(3, t + 5);
    wait_until(t + 8); clear = '1;
    wait_until(t + 9); clear = '0;
    check("ind_cleared", event_flag, 0);
    for (int c = 0; c < CH; c++) begin
      rm[c] = 2'($urandom_range(0, 3));
      set_mode(c, rm[c]);
    end
    lvl = '0; ev = '0; ov = '0;
    base = cyc;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < CH; c++) begin
        wait_until(base + 1 + r * 10 + c * 2);
        lvl[c] = ~lvl[c];
        signal_in[c] = lvl[c];
        if (lvl[c] ? rm[c][0] : rm[c][1]) begin
          expect_pulse(c, cyc + 5);
          if (ev[c]) ov[c] = 1'b1;
          ev[c] = 1'b1;
        end
      end
    end
    wait_until(cyc + 10);
    check("ind_level", level_out, lvl);
    check("ind_event", event_flag, ev);
    check("ind_overrun", overrun, ov);
    check("ind_any", any_event, |ev);

    wait_until(cyc + 2);
    foreach (sb[j]) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending_pulse ch%0d: never seen, required at cycle %0d", sb[j].ch, sb[j].at);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Multi-channel, parametrised edge detector for the SPI IP, used on asynchronous pins (CS_n, external triggers) and on internal strobes.
Each channel has:
- a synchroniser;
- a glitch filter;
- a per-channel edge mode (off/rise/fall/both);
- a one-clock pulse output;
- sticky write-1-to-clear event and overrun flags for the register block.

Replaces single-channel, unsynchronised, unfiltered detection.

Parameters:
CHANNELS, 4, number of independent channels (1..32)
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2; 0 = input already synchronous, bypass)
FILTER_CYCLES, 3, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
signal_in  in  CHANNELS  raw input levels, may be asynchronous
mode  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clear  in  CHANNELS  write-1-to-clear strobe for event_flag/overrun of channel i
level_out  out  CHANNELS  filtered, synchronised level
pulse_out  out  CHANNELS  registered one-clock pulse on selected edge
event_flag  out  CHANNELS  sticky: selected edge seen since last clear
overrun  out  CHANNELS  sticky: edge seen while event_flag already set
any_event  out  1  OR of event_flag

Behaviour:
Reset and clocking:
- Reset value of all registers and outputs is 0: sync chain, filtered level, counter, pulse_out, event_flag, overrun.
- Reset dominates every other input in the same cycle.
- Reset mid-filter discards the pending count; no pulse is produced.
- Since level resets to 0, an input held high through reset yields a rise after release (intended).

Synchroniser:
- signal_in[i] passes through SYNC_STAGES flops, giving s[i].

Filter (per channel):
- Counter width is $clog2(FILTER_CYCLES)+1.
- If s == level, the counter is cleared to 0.
- If s != level and counter == FILTER_CYCLES-1, level toggles and the counter clears.
- Otherwise, the counter increments.
- A pulse shorter than FILTER_CYCLES cycles at s is suppressed entirely.

Latency:
- An input change stable before edge 1 appears on level_out after edge SYNC_STAGES+FILTER_CYCLES.
- pulse_out asserts at that same edge, for exactly one cycle.

Edge qualification:
- Edges are qualified at the toggle edge using the current mode.
- rise = toggle and the new level is 1; fall = toggle and the new level is 0.
- Mode 00: level_out still tracks; no pulse, no flag.
- Mode changes take effect on the next toggle; pending counts are unaffected.

event_flag[i]:
- Set on pulse; cleared by clear[i].
- Simultaneous pulse and clear leaves event_flag = 1 (event never lost).

overrun[i]:
- Set on pulse when event_flag[i] == 1 and clear[i] == 0.
- Cleared by clear[i].
- Simultaneous pulse and clear leaves overrun = 0.

Timing and independence:
- Back-to-back edges are at least FILTER_CYCLES cycles apart by construction.
- No channel affects another.
- any_event is combinational OR of registered flags.

Decomposition:
Package edge_detect_pkg holds:
- mode_t (2-bit typedef);
- constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.

Sub-module edge_detect_chan contains one channel: sync chain, filter counter, edge qualification, pulse and sticky flags.
- It takes SYNC_STAGES and FILTER_CYCLES.
- Top instantiates CHANNELS copies via generate and forms any_event.

Test Plan:
(CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3)
- Rise: mode[1:0]=01, signal_in[0] 0->1 before edge 1, held -> after edge 5, level_out[0]=1 and pulse_out[0]=1; pulse_out[0]=0 after edge 6; event_flag[0]=1, any_event=1.
- Glitch: mode=11 on ch1, signal_in[1] high for exactly 2 cycles -> level_out[1], pulse_out[1] and event_flag[1] stay 0. Same stimulus at 3 cycles -> rise pulse, then fall pulse 3 cycles later.
- Modes: ch2 mode=10 -> rise yields level_out[2]=1, no pulse; fall yields one pulse. ch3 mode=00 -> level tracks, no pulse or flag. ch3 mode=11 -> pulse on both edges.
- Flags: two ch0 rise events without clear -> overrun[0]=1. Then clear[0]=1 -> both flags 0 next cycle. Clear coincident with a pulse -> event_flag[0]=1, overrun[0]=0.
- Reset: assert reset on the cycle the counter reaches 1 -> all outputs 0 next cycle, no pulse. Input held high through reset -> pulse_out exactly 5 cycles after the last reset cycle.
- Independence: all 4 channels toggled on staggered cycles with random modes -> pulse_out matches a per-channel reference model; no cross-channel effect.
